// File: rtl/life_lfsr_core.sv
// life_lfsr_core: 8x8 Game of Life grid seeded from a 64-bit Fibonacci LFSR.
// Define LIFE_TORUS_EN to make the grid wrap at its edges.
module life_lfsr_core (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] seed,
  input  logic        seed_load,
  input  logic        rundom,
  input  logic        load,
  input  logic        run,
  input  logic        display,
  output logic [63:0] hdmi
);

  logic [63:0] r_grid;
  logic [63:0] r_lfsr;
  logic        r_run_q;
  logic        r_rundom_q;
  logic [63:0] w_next;
  logic        w_fb;
  logic [63:0] w_seed;

  // Neighbour lookup; off-grid cells are dead unless the grid wraps.
  function automatic logic cell_at(
    input logic [63:0] g,
    input int          r,
    input int          c
  );
    logic [5:0] idx;
    idx = '0;
`ifdef LIFE_TORUS_EN
    idx = 6'(((r + 8) % 8) * 8 + ((c + 8) % 8));
    return g[idx];
`else
    if (r < 0 || r > 7 || c < 0 || c > 7) begin
      return 1'b0;
    end
    idx = 6'(r * 8 + c);
    return g[idx];
`endif
  endfunction

  assign w_fb   = r_lfsr[63] ^ r_lfsr[62]
                ^ r_lfsr[60] ^ r_lfsr[59];
  assign w_seed = (seed == 64'h0) ? 64'h1 : seed;

  // Next generation: count 8 neighbours, apply B3/S23.
  always_comb begin
    logic [3:0] n;
    logic [5:0] idx;
    w_next = '0;
    n      = '0;
    idx    = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = '0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              n = n + {3'b000, cell_at(r_grid, r + dr, c + dc)};
            end
          end
        end
        idx = 6'(r * 8 + c);
        w_next[idx] = (n == 4'd3) | (r_grid[idx] & (n == 4'd2));
      end
    end
  end

  // Capture step enables one cycle ahead of use.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run_q    <= 1'b0;
      r_rundom_q <= 1'b0;
    end else begin
      r_run_q    <= run;
      r_rundom_q <= rundom;
    end
  end

  // LFSR: seed load beats stepping; zero seed is replaced by 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= 64'h1;
    end else if (seed_load) begin
      r_lfsr <= w_seed;
    end else if (r_rundom_q) begin
      r_lfsr <= {r_lfsr[62:0], w_fb};
    end
  end

  // Grid: load from pre-edge LFSR beats advancing a generation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grid <= 64'h0;
    end else if (load) begin
      r_grid <= r_lfsr;
    end else if (r_run_q) begin
      r_grid <= w_next;
    end
  end

  assign hdmi = display ? r_lfsr : r_grid;

endmodule

// File: tb/tb_life_lfsr_core.sv
// tb_life_lfsr_core: directed vectors for life_lfsr_core.
// Expected frames are hand-derived from the life and LFSR rules.
module tb_life_lfsr_core;

  logic        clk;
  logic        reset_n;
  logic [63:0] seed;
  logic        seed_load;
  logic        rundom;
  logic        load;
  logic        run;
  logic        display;
  logic [63:0] hdmi;

  int n_cmp;
  int n_bad;

  life_lfsr_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seed      (seed),
    .seed_load (seed_load),
    .rundom    (rundom),
    .load      (load),
    .run       (run),
    .display   (display),
    .hdmi      (hdmi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(
    input logic        sel,
    output logic [63:0] v
  );
    display = sel;
    #1;
    v = hdmi;
  endtask

  task automatic do_seed(input logic [63:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic gens(input int n);
    run = 1'b1;
    repeat (n) tick();
    run = 1'b0;
    tick();
  endtask

  task automatic set_grid(input logic [63:0] g);
    do_seed(g);
    do_load();
  endtask

  logic [63:0] v;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    seed      = '0;
    seed_load = 1'b0;
    rundom    = 1'b0;
    load      = 1'b0;
    run       = 1'b0;
    display   = 1'b0;
    #12;
    peek(1'b0, v); chk("rst_grid", v, 64'h0);
    peek(1'b1, v); chk("rst_lfsr", v, 64'h1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    do_seed(64'h0);
    peek(1'b1, v); chk("seed_zero", v, 64'h1);

    do_seed(64'h8000_0000_0000_0000);
    rundom = 1'b1;
    tick();
    rundom = 1'b0;
    peek(1'b1, v); chk("rnd_lat0", v, 64'h8000_0000_0000_0000);
    tick();
    peek(1'b1, v); chk("rnd_msb", v, 64'h1);

    rundom = 1'b1;
    tick();
    rundom = 1'b0;
    peek(1'b1, v); chk("rnd_lat1", v, 64'h1);
    tick();
    peek(1'b1, v); chk("rnd_one", v, 64'h2);

    set_grid(64'h0000_0000_1C00_0000);
    peek(1'b0, v); chk("blk_load", v, 64'h0000_0000_1C00_0000);
    gens(1);
    peek(1'b0, v); chk("blk_g1", v, 64'h0000_0008_0808_0000);
    gens(1);
    peek(1'b0, v); chk("blk_g2", v, 64'h0000_0000_1C00_0000);

    set_grid(64'h0000_0000_0000_0303);
    gens(5);
    peek(1'b0, v); chk("block5", v, 64'h0000_0000_0000_0303);

    set_grid(64'h1);
    gens(1);
    peek(1'b0, v); chk("lonely", v, 64'h0);

    set_grid(64'h0000_0000_0001_0101);
    gens(1);
`ifdef LIFE_TORUS_EN
    peek(1'b0, v); chk("edge", v, 64'h0000_0000_0000_8300);
`else
    peek(1'b0, v); chk("edge", v, 64'h0000_0000_0000_0300);
`endif

    set_grid(64'h0000_0000_1C00_0000);
    do_seed(64'h1234_5678_9ABC_DEF0);
    run = 1'b1;
    tick();
    load = 1'b1;
    tick();
    load = 1'b0;
    run  = 1'b0;
    peek(1'b0, v); chk("load_prio", v, 64'h1234_5678_9ABC_DEF0);
    tick();
    tick();

    seed      = 64'h0F0F_0000_0000_00F0;
    seed_load = 1'b1;
    load      = 1'b1;
    tick();
    seed_load = 1'b0;
    load      = 1'b0;
    peek(1'b0, v); chk("both_grid", v, 64'h1234_5678_9ABC_DEF0);
    peek(1'b1, v); chk("both_lfsr", v, 64'h0F0F_0000_0000_00F0);

    set_grid(64'h0000_0000_1C00_0000);
    run    = 1'b1;
    rundom = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    peek(1'b0, v); chk("arst_grid", v, 64'h0);
    peek(1'b1, v); chk("arst_lfsr", v, 64'h1);
    run    = 1'b0;
    rundom = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    peek(1'b1, v); chk("post_lfsr", v, 64'h1);
    peek(1'b0, v); chk("post_grid", v, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
